arbiter2_rr: RTL and testbench
==============================

# arbiter2_rr

Two-input, one-output round-robin merge node for the 9-bit NoC packet format: bits [8:5] are the 4-bit destination address and bits [4:0] the payload. It shares one upstream tree link between two child links, so it is the complement of the address decoder that splits a link on the downstream path. Each input has a one-entry buffer, the output is a single register stage, and per-port grant counters support bandwidth checks.

## Interface
- W, 9, packet width; all data buses are W bits (address at [W-1:W-4])
- CNT_W, 8, width of each saturating grant counter
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- in0_data  in  W  packet from child 0
- in0_valid  in  1  child 0 offers in0_data
- in0_ready  out  1  buffer 0 empty; transfer occurs when valid&ready at an edge
- in1_data, in1_valid, in1_ready  same as port 0, for child 1
- out_data  out  W  granted packet
- out_valid  out  1  out_data holds a packet
- out_ready  in  1  upstream accepts; transfer occurs when valid&ready at an edge
- out_sel  out  1  source port of the packet in out_data (0 or 1); valid when out_valid=1
- grant_cnt0, grant_cnt1  out  CNT_W  number of packets granted from each port, saturating

## Operation
- Buffers: buf_full_i is set on in_i_valid&in_i_ready and cleared when buffer i is granted. in_i_ready = ~buf_full_i, decoded from a register only with no combinational input path. Data is latched unchanged.
- Output register load condition: load = ~out_valid | out_ready.
- Arbitration is evaluated each cycle when load=1:
  - If neither buffer is full, no grant occurs. out_valid goes to 0 if it was drained.
  - If exactly one buffer is full, that port is granted.
  - If both are full, the port indicated by priority pointer prio is granted.
- On a grant to port g:
  - out_data is set to buf_g and out_sel to g.
  - out_valid is set to 1.
  - buf_full_g is cleared.
  - prio is set to ~g.
  - grant_cnt_g is incremented, holding at 2^CNT_W-1.
- prio changes only on a grant. A port that wins with the other port idle still hands priority to the other port.
- While out_valid=1 and out_ready=0, out_data and out_sel are held stable and nothing is granted.
- Packets from the same port leave in arrival order. Packets are never dropped, duplicated or modified.
- Reset values: buf_full_0 and buf_full_1 = 0, so in0_ready and in1_ready = 1 in the first cycle after reset. out_valid = 0; out_data = 0; out_sel = 0; prio = 0; both counters = 0.
- Reset asserted mid-operation discards all buffered and output packets at that edge, with no handshake.

## Timing
- Minimum latency is 2 edges. A packet accepted at edge k is in out_data after edge k+1, and out_valid is visible in cycle k+1 to k+2.
- Single active port: one packet every 2 cycles. The buffer frees at edge k+1, so in_ready is high in the following cycle and the next accept is at edge k+2.
- Both ports saturated with out_ready=1: one packet per cycle on out, strictly alternating 0,1,0,1…
- Same-edge accept into buffer i and grant of buffer i is impossible, because in_i_ready=0 while the buffer is full.
- With out_ready=0 indefinitely: both buffers fill, both in_ready go low, and the output stays frozen. Recovery starts on the first out_ready=1 edge.
- There is no combinational path from any input to any output.

## Test plan
1. Reset, then idle: out_valid=0, in0_ready=in1_ready=1, counters=0, out_sel=0.
2. Port 0 sends 9'h0C5 once, out_ready=1 → out_valid high for 1 cycle with out_data=9'h0C5 and out_sel=0, 2 edges after accept. grant_cnt0=1.
3. Both ports saturated with distinct sequences (port 0: 9'h000…, port 1: 9'h100…), out_ready=1 → out_sel alternates starting with 0. Per-port order is preserved; after 20 output packets, both counters=10.
4. Backpressure: load both buffers, then hold out_ready=0 for 10 cycles → out_data stable, both in_ready=0. Then raise out_ready → both packets drain in consecutive cycles, in priority order.
5. Saturation: 300 packets from port 1 only → grant_cnt1=255, grant_cnt0=0, with no packet loss.
6. Assert reset while both buffers are full and out_valid=1 → the next cycle matches all reset values, and no stale packet appears afterward.

Source files
------------

// File: rtl/arbiter2_rr.sv
// rtl/arbiter2_rr.sv - two-input round-robin merge node with per-port buffers and grant counters

// One-entry input buffer; ready is decoded from the full flag only.
module arbiter2_rr_buf #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         take,
  output logic [W-1:0] data,
  output logic         full
);

  assign in_ready = ~full;

  // Fill on handshake, empty on grant; both cannot coincide since ready=~full.
  always_ff @(posedge clk) begin
    if (reset) begin
      full <= 1'b0;
      data <= '0;
    end else if (in_valid && !full) begin
      full <= 1'b1;
      data <= in_data;
    end else if (take) begin
      full <= 1'b0;
    end
  end

endmodule

// Saturating grant counter.
module arbiter2_rr_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  // Count grants, holding at the all-ones value.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// Top: merges two child links onto one registered upstream link.
module arbiter2_rr #(
  parameter int W     = 9,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [W-1:0]     in0_data,
  input  logic             in0_valid,
  output logic             in0_ready,
  input  logic [W-1:0]     in1_data,
  input  logic             in1_valid,
  output logic             in1_ready,
  output logic [W-1:0]     out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sel,
  output logic [CNT_W-1:0] grant_cnt0,
  output logic [CNT_W-1:0] grant_cnt1
);

  logic [W-1:0] buf0_data;
  logic [W-1:0] buf1_data;
  logic         full0;
  logic         full1;
  logic         prio;
  logic         load;
  logic         grant0;
  logic         grant1;

  arbiter2_rr_buf #(.W(W)) u_buf0 (
    .clk      (clk),
    .reset    (reset),
    .in_data  (in0_data),
    .in_valid (in0_valid),
    .in_ready (in0_ready),
    .take     (grant0),
    .data     (buf0_data),
    .full     (full0)
  );

  arbiter2_rr_buf #(.W(W)) u_buf1 (
    .clk      (clk),
    .reset    (reset),
    .in_data  (in1_data),
    .in_valid (in1_valid),
    .in_ready (in1_ready),
    .take     (grant1),
    .data     (buf1_data),
    .full     (full1)
  );

  // The output stage can take a new packet when empty or being drained.
  assign load = ~out_valid | out_ready;

  // Grant a lone full buffer outright; on contention follow the priority pointer.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (load) begin
      if (full0 && (!full1 || !prio)) begin
        grant0 = 1'b1;
      end else if (full1) begin
        grant1 = 1'b1;
      end
    end
  end

  // Output register and priority pointer; priority always passes to the loser side.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      out_sel   <= 1'b0;
      prio      <= 1'b0;
    end else if (load) begin
      if (grant0 || grant1) begin
        out_data  <= grant1 ? buf1_data : buf0_data;
        out_sel   <= grant1;
        out_valid <= 1'b1;
        prio      <= grant0;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

  arbiter2_rr_cnt #(.CNT_W(CNT_W)) u_cnt0 (
    .clk   (clk),
    .reset (reset),
    .inc   (grant0),
    .count (grant_cnt0)
  );

  arbiter2_rr_cnt #(.CNT_W(CNT_W)) u_cnt1 (
    .clk   (clk),
    .reset (reset),
    .inc   (grant1),
    .count (grant_cnt1)
  );

endmodule

// File: tb/tb_arbiter2_rr.sv
// tb/tb_arbiter2_rr.sv - scoreboard bench for the two-input round-robin merge node

module tb_arbiter2_rr;

  localparam int W     = 9;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic [W-1:0]     in0_data;
  logic             in0_valid;
  logic             in0_ready;
  logic [W-1:0]     in1_data;
  logic             in1_valid;
  logic             in1_ready;
  logic [W-1:0]     out_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_sel;
  logic [CNT_W-1:0] grant_cnt0;
  logic [CNT_W-1:0] grant_cnt1;

  int n_checks = 0;
  int n_fail   = 0;
  int n_out    = 0;
  int n_base;

  logic [W-1:0] q0[$];
  logic [W-1:0] q1[$];
  logic [W-1:0] mon_exp;
  bit           alt_check = 1'b0;
  logic         exp_sel;

  arbiter2_rr #(.W(W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .in0_data   (in0_data),
    .in0_valid  (in0_valid),
    .in0_ready  (in0_ready),
    .in1_data   (in1_data),
    .in1_valid  (in1_valid),
    .in1_ready  (in1_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sel    (out_sel),
    .grant_cnt0 (grant_cnt0),
    .grant_cnt1 (grant_cnt1)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: inputs stable between posedge+1 and the next posedge, so the
  // negedge sees exactly the handshakes that complete at the coming edge.
  always @(negedge clk) begin
    if (!reset) begin
      if (in0_valid && in0_ready) q0.push_back(in0_data);
      if (in1_valid && in1_ready) q1.push_back(in1_data);
      if (out_valid && out_ready) begin
        n_out++;
        if (out_sel) begin
          check_eq("sb_nonempty1", 32'(q1.size() > 0), 32'd1);
          mon_exp = (q1.size() > 0) ? q1.pop_front() : 'x;
        end else begin
          check_eq("sb_nonempty0", 32'(q0.size() > 0), 32'd1);
          mon_exp = (q0.size() > 0) ? q0.pop_front() : 'x;
        end
        check_eq("sb_data", 32'(out_data), 32'(mon_exp));
        if (alt_check) begin
          check_eq("alt_sel", 32'(out_sel), 32'(exp_sel));
          exp_sel = ~exp_sel;
        end
      end
    end
  end

  task automatic do_reset();
    in0_valid = 1'b0;
    in1_valid = 1'b0;
    reset     = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset     = 1'b0;
    q0.delete();
    q1.delete();
    alt_check = 1'b0;
  endtask

  task automatic drive_port(input int p, input int n, input logic [W-1:0] base);
    int cyc;
    bit rdy;
    for (int i = 0; i < n; i++) begin
      cyc = 0;
      rdy = 1'b0;
      if (p == 0) begin
        in0_data  = base + W'(i);
        in0_valid = 1'b1;
      end else begin
        in1_data  = base + W'(i);
        in1_valid = 1'b1;
      end
      while (!rdy && cyc < 200) begin
        @(negedge clk);
        rdy = (p == 0) ? in0_ready : in1_ready;
        @(posedge clk); #1;
        cyc++;
      end
      check_eq("drv_accept", 32'(rdy), 32'd1);
    end
    if (p == 0) in0_valid = 1'b0;
    else        in1_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int c;
    c = 0;
    while ((q0.size() != 0 || q1.size() != 0 || out_valid) && c < 500) begin
      @(posedge clk); #1;
      c++;
    end
    check_eq("idle_reached", 32'(c < 500), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    in0_data  = '0;
    in1_data  = '0;
    out_ready = 1'b0;
    do_reset();

    // 1: reset state
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_in0_ready", 32'(in0_ready), 32'd1);
    check_eq("rst_in1_ready", 32'(in1_ready), 32'd1);
    check_eq("rst_cnt0", 32'(grant_cnt0), 32'd0);
    check_eq("rst_cnt1", 32'(grant_cnt1), 32'd0);
    check_eq("rst_out_sel", 32'(out_sel), 32'd0);
    check_eq("rst_out_data", 32'(out_data), 32'd0);

    // 2: single packet latency
    out_ready = 1'b1;
    in0_data  = 9'h0C5;
    in0_valid = 1'b1;
    @(posedge clk); #1;
    in0_valid = 1'b0;
    check_eq("t2_busy_ready", 32'(in0_ready), 32'd0);
    check_eq("t2_valid_early", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check_eq("t2_valid", 32'(out_valid), 32'd1);
    check_eq("t2_data", 32'(out_data), 32'h0C5);
    check_eq("t2_sel", 32'(out_sel), 32'd0);
    check_eq("t2_cnt0", 32'(grant_cnt0), 32'd1);
    check_eq("t2_ready_back", 32'(in0_ready), 32'd1);
    @(posedge clk); #1;
    check_eq("t2_valid_drop", 32'(out_valid), 32'd0);

    // 3: both saturated, strict alternation from port 0
    do_reset();
    out_ready = 1'b1;
    alt_check = 1'b1;
    exp_sel   = 1'b0;
    n_base    = n_out;
    fork
      drive_port(0, 10, 9'h000);
      drive_port(1, 10, 9'h100);
    join
    wait_idle();
    alt_check = 1'b0;
    check_eq("t3_n_out", 32'(n_out - n_base), 32'd20);
    check_eq("t3_cnt0", 32'(grant_cnt0), 32'd10);
    check_eq("t3_cnt1", 32'(grant_cnt1), 32'd10);

    // 4: backpressure freezes output, then drains in priority order
    do_reset();
    out_ready = 1'b0;
    alt_check = 1'b1;
    exp_sel   = 1'b0;
    n_base    = n_out;
    fork
      drive_port(0, 2, 9'h0A0);
      drive_port(1, 2, 9'h1A0);
      begin
        repeat (3) begin
          @(posedge clk); #1;
        end
        for (int i = 0; i < 10; i++) begin
          check_eq("t4_hold_valid", 32'(out_valid), 32'd1);
          check_eq("t4_hold_data", 32'(out_data), 32'h0A0);
          check_eq("t4_hold_sel", 32'(out_sel), 32'd0);
          check_eq("t4_in0_ready", 32'(in0_ready), 32'd0);
          check_eq("t4_in1_ready", 32'(in1_ready), 32'd0);
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    wait_idle();
    alt_check = 1'b0;
    check_eq("t4_n_out", 32'(n_out - n_base), 32'd4);

    // 5: counter saturation on port 1
    do_reset();
    out_ready = 1'b1;
    n_base    = n_out;
    drive_port(1, 300, 9'h000);
    wait_idle();
    check_eq("t5_n_out", 32'(n_out - n_base), 32'd300);
    check_eq("t5_cnt1", 32'(grant_cnt1), 32'd255);
    check_eq("t5_cnt0", 32'(grant_cnt0), 32'd0);

    // 6: reset while full and output valid
    do_reset();
    out_ready = 1'b0;
    in0_data  = 9'h055;
    in1_data  = 9'h1AA;
    in0_valid = 1'b1;
    in1_valid = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    check_eq("t6_pre_valid", 32'(out_valid), 32'd1);
    check_eq("t6_pre_in0_ready", 32'(in0_ready), 32'd0);
    check_eq("t6_pre_in1_ready", 32'(in1_ready), 32'd0);
    in0_valid = 1'b0;
    in1_valid = 1'b0;
    reset     = 1'b1;
    @(posedge clk); #1;
    reset     = 1'b0;
    q0.delete();
    q1.delete();
    n_base    = n_out;
    check_eq("t6_out_valid", 32'(out_valid), 32'd0);
    check_eq("t6_out_data", 32'(out_data), 32'd0);
    check_eq("t6_out_sel", 32'(out_sel), 32'd0);
    check_eq("t6_in0_ready", 32'(in0_ready), 32'd1);
    check_eq("t6_in1_ready", 32'(in1_ready), 32'd1);
    check_eq("t6_cnt0", 32'(grant_cnt0), 32'd0);
    check_eq("t6_cnt1", 32'(grant_cnt1), 32'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check_eq("t6_no_stale", 32'(out_valid), 32'd0);
    end
    check_eq("t6_n_out", 32'(n_out - n_base), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
